// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: processes SLICE bits per clock through a ripple
// slice with a registered carry, with optional signed saturation and C/V/Z/N flags.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [1:0]       dbg_state
);

  localparam int K  = WIDTH / SLICE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_params
    $error("addsub_seq: WIDTH must be a positive multiple of SLICE");
  end

  // Handshake: start is sampled only in IDLE or DONE; the accepting edge moves to RUN,
  // busy stays high for exactly K cycles, and done pulses for one cycle with the results.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              sat_q;
  logic              c_q;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  shadow;

  int                idx;
  logic [SLICE-1:0]  a_s;
  logic [SLICE-1:0]  b_s;
  logic [SLICE:0]    s_sum;
  logic              c_msb_in;
  logic              raw_ovf;
  logic              last;
  logic [WIDTH-1:0]  raw_res;
  logic [WIDTH-1:0]  fin_res;

  assign dbg_state = state;

  always_comb begin
    idx   = int'(cnt) * SLICE;
    a_s   = a_q[idx +: SLICE];
    b_s   = b_q[idx +: SLICE];
    s_sum = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, c_q};
    last  = (cnt == CW'(K - 1));
    // Carry into the top bit is recovered from that bit's sum and its two operand bits.
    c_msb_in = s_sum[SLICE-1] ^ a_s[SLICE-1] ^ b_s[SLICE-1];
    raw_ovf  = s_sum[SLICE] ^ c_msb_in;
    raw_res  = shadow;
    raw_res[WIDTH-1 -: SLICE] = s_sum[SLICE-1:0];
    fin_res  = raw_res;
    if (sat_q && raw_ovf) begin
      fin_res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sat_q    <= 1'b0;
      c_q      <= 1'b0;
      cnt      <= '0;
      shadow   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{mode[0]}};
            sat_q <= mode[1];
            c_q   <= mode[0];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          shadow[idx +: SLICE] <= s_sum[SLICE-1:0];
          c_q <= s_sum[SLICE];
          if (last) begin
            result   <= fin_res;
            carry    <= s_sum[SLICE];
            overflow <= raw_ovf;
            zero     <= (fin_res == '0);
            negative <= fin_res[WIDTH-1];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
